// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion and arithmetic stages.
package bcd_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    // Conditional +3; a 4-bit add is enough because the result never exceeds 12.
    always_comb begin
        q = d;
        if (d >= ADJ_THRESH) begin
            q = d + ADJ_VAL;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-add-3).
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    b2b_state_t       state;
    b2b_state_t       state_nxt;
    logic [BIN_W-1:0] shreg;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic             last;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .d (scratch[g*DIGIT_W +: DIGIT_W]),
                .q (adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Adjusted scratch shifted left with the next binary bit entering at the bottom.
    always_comb begin
        shifted = {adj[BCD_W-2:0], shreg[BIN_W-1]};
        last    = (cnt == CNT_W'(BIN_W - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift/adjust, result registers.
    // Result registers load from the final shift so they are already valid in the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    ovf_acc <= ovf_acc | adj[BCD_W-1];
                    if (last) begin
                        bcd_out  <= shifted;
                        overflow <= ovf_acc | adj[BCD_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq with a 3-digit and a 2-digit instance.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int checks = 0;
    int errors = 0;

    logic [12:0] q3[$];
    logic [8:0]  q2[$];
    logic [12:0] e3;
    logic [8:0]  e2;
    logic        prev3 = 1'b0;
    logic        prev2 = 1'b0;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy3),
        .done     (done3),
        .bcd_out  (bcd3),
        .overflow (ovf3)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy2),
        .done     (done2),
        .bcd_out  (bcd2),
        .overflow (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] ref3(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {1'b0, h, t, o};
    endfunction

    function automatic logic [8:0] ref2(input int v);
        logic [3:0] t, o;
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {(v >= 100), t, o};
    endfunction

    // Scoreboard: pop and compare whenever either instance pulses done.
    always @(negedge clk) begin
        if (done3) begin
            chk("done3_pulse", 32'(prev3), 0);
            if (q3.size() == 0) begin
                chk("done3_unexpected", 1, 0);
            end else begin
                e3 = q3.pop_front();
                chk("bcd3", 32'(bcd3), 32'(e3[11:0]));
                chk("ovf3", 32'(ovf3), 32'(e3[12]));
            end
        end
        if (done2) begin
            chk("done2_pulse", 32'(prev2), 0);
            if (q2.size() == 0) begin
                chk("done2_unexpected", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("bcd2", 32'(bcd2), 32'(e2[7:0]));
                chk("ovf2", 32'(ovf2), 32'(e2[8]));
            end
        end
        prev3 <= done3;
        prev2 <= done2;
    end

    task automatic push(input int v);
        q3.push_back(ref3(v));
        q2.push_back(ref2(v));
    endtask

    // Wait (bounded) for done; returns cycles since the cycle after start and busy count.
    task automatic wait_done(input int lat0, output int lat, output int busyc);
        lat   = lat0;
        busyc = 0;
        while (!done3 && lat < 40) begin
            if (busy3) busyc++;
            @(negedge clk);
            lat++;
        end
        if (!done3) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input int v);
        int lat, busyc;
        @(negedge clk);
        bin_in = 8'(v);
        start  = 1'b1;
        push(v);
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat, busyc);
        chk("latency", 32'(lat), 9);
        chk("busy_cycles", 32'(busyc), 8);
        chk("done_both", 32'(done2), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bcd3"}, 32'(bcd3), 0);
        chk({tag, "_ovf3"}, 32'(ovf3), 0);
        chk({tag, "_bcd2"}, 32'(bcd2), 0);
        chk({tag, "_busy"}, 32'(busy3), 0);
        chk({tag, "_done"}, 32'(done3), 0);
    endtask

    initial begin
        int lat, busyc;
        logic seen;
        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #3 rst = 1'b1;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("post_reset");

        // Zero, all-ones, and a reset pulse while idle with a nonzero result held.
        run(0);
        run(255);
        @(negedge clk);
        chk("hold_bcd3", 32'(bcd3), 32'h255);
        rst = 1'b1;
        #1 chk_zero("idle_rst");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done3;
        end
        chk("idle_rst_nodone", 32'(seen), 0);
        chk_zero("idle_rst_after");

        // Start while busy is ignored; start during the done cycle is ignored too.
        @(negedge clk);
        bin_in = 8'd99;
        start  = 1'b1;
        push(99);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bin_in = 8'd42;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'd0;
        wait_done(4, lat, busyc);
        chk("ignored_latency", 32'(lat), 9);
        bin_in = 8'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 32'(busy3), 0);
        run(42);

        // Reset during a conversion aborts it without a done pulse.
        @(negedge clk);
        bin_in = 8'd200;
        start  = 1'b1;
        push(200);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q3.delete();
        q2.delete();
        #1 chk_zero("abort_rst");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | done3 | done2;
        end
        chk("abort_nodone", 32'(seen), 0);
        chk_zero("abort_after");
        run(7);

        // Two-digit overflow boundaries, then the full sweep.
        run(200);
        run(99);
        run(100);
        for (int v = 0; v < 256; v++) begin
            run(v);
        end

        @(negedge clk);
        chk("q3_drained", 32'(q3.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
